tlm_batch_pingpong_driver: RTL and testbench

//  Successor to the single-buffer TLM pair driver. A software or DPI loader writes

---
 rtl/tlm_batch_pingpong_driver.sv | 245 ++++++++++++++++++++++++
 tb/tb_tlm_batch_pingpong_driver.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlm_batch_pingpong_driver.sv
// Ping-pong batch buffer: a loader fills one bank while the other streams items to the DUT bus.
// Optional macro TLM_GAP_EN: insert GAP_CYCLES idle cycles after every output handshake.
module tlm_batch_pingpong_driver #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ITEM_WIDTH = 8,
    parameter int unsigned DEPTH      = 1000,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned BCNT_W     = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           ld_valid_i,
    output logic                           ld_ready_o,
    input  logic [NUM_CH*ITEM_WIDTH-1:0]   ld_data_i,
    input  logic                           ld_last_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [NUM_CH*ITEM_WIDTH-1:0]   out_data_o,
    output logic                           out_last_o,
    output logic                           batch_done_o,
    output logic [BCNT_W-1:0]              batch_cnt_o
);

    localparam int unsigned DW = NUM_CH * ITEM_WIDTH;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || GAP_CYCLES < 1) begin : g_param_check
        $error("tlm_batch_pingpong_driver: DEPTH must be >= 2 and GAP_CYCLES >= 1");
    end

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_e;
    typedef enum logic [1:0] {R_IDLE, R_STREAM, R_GAP} rd_state_e;

    logic [DW-1:0] r_mem [2][DEPTH];
    bank_e         r_bank [2];
    logic [LW-1:0] r_len [2];
    logic          r_wr_sel;
    logic          r_rd_sel;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_ld_ready;
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          r_out_last;
    logic          r_batch_done;
    logic [BCNT_W-1:0] r_batch_cnt;
    rd_state_e     r_state;

    rd_state_e     w_state_nxt;
    bank_e         w_bank_nxt [2];
    logic          w_wr_sel_nxt;
    logic          w_ld_ready_nxt;
    logic          w_ld_hs;
    logic          w_close;
    logic          w_hs;
    logic          w_start;
    logic          w_start_sel;
    logic          w_adv;
    logic          w_fin;
    logic          w_show;
    logic [PW-1:0] w_rd_nxt;

`ifdef TLM_GAP_EN
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    logic [GW-1:0] r_gap_cnt;
`endif

    assign w_ld_hs  = ld_valid_i && r_ld_ready;
    assign w_close  = w_ld_hs && (ld_last_i || (r_wr_ptr == PW'(DEPTH - 1)));
    assign w_hs     = r_out_valid && out_ready_i;
    assign w_rd_nxt = r_rd_ptr + PW'(1);

    // Reader FSM state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Reader next-state and datapath strobes; w_start_sel names the bank whose item 0 is loaded
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_start_sel = r_rd_sel;
        w_adv       = 1'b0;
        w_fin       = 1'b0;
        w_show      = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (r_bank[r_rd_sel] == B_FULL) begin
                    w_start     = 1'b1;
                    w_state_nxt = R_STREAM;
                end
            end
            R_STREAM: begin
                if (w_hs) begin
                    if (r_out_last) begin
                        w_fin = 1'b1;
`ifdef TLM_GAP_EN
                        w_state_nxt = R_GAP;
`else
                        if (r_bank[~r_rd_sel] == B_FULL) begin
                            w_start     = 1'b1;
                            w_start_sel = ~r_rd_sel;
                        end else begin
                            w_state_nxt = R_IDLE;
                        end
`endif
                    end else begin
                        w_adv = 1'b1;
`ifdef TLM_GAP_EN
                        w_state_nxt = R_GAP;
`endif
                    end
                end
            end
`ifdef TLM_GAP_EN
            R_GAP: begin
                if (r_gap_cnt == GW'(1)) begin
                    if (r_bank[r_rd_sel] == B_DRAINING) begin
                        w_show      = 1'b1;
                        w_state_nxt = R_STREAM;
                    end else if (r_bank[r_rd_sel] == B_FULL) begin
                        w_start     = 1'b1;
                        w_state_nxt = R_STREAM;
                    end else begin
                        w_state_nxt = R_IDLE;
                    end
                end
            end
`endif
            default: w_state_nxt = R_IDLE;
        endcase
    end

    // Bank bookkeeping: writer and reader always touch different banks
    always_comb begin
        w_bank_nxt   = r_bank;
        w_wr_sel_nxt = r_wr_sel;
        if (w_ld_hs) begin
            w_bank_nxt[r_wr_sel] = w_close ? B_FULL : B_FILLING;
            if (w_close) begin
                w_wr_sel_nxt = ~r_wr_sel;
            end
        end
        if (w_fin) begin
            w_bank_nxt[r_rd_sel] = B_EMPTY;
        end
        if (w_start) begin
            w_bank_nxt[w_start_sel] = B_DRAINING;
        end
        w_ld_ready_nxt = (w_bank_nxt[w_wr_sel_nxt] == B_EMPTY)
                      || (w_bank_nxt[w_wr_sel_nxt] == B_FILLING);
    end

    // Item storage needs no reset; bank state alone decides what is valid
    always_ff @(posedge clk_i) begin
        if (w_ld_hs) begin
            r_mem[r_wr_sel][r_wr_ptr] <= ld_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_bank     <= '{B_EMPTY, B_EMPTY};
            r_len      <= '{LW'(0), LW'(0)};
            r_wr_sel   <= 1'b0;
            r_wr_ptr   <= '0;
            r_ld_ready <= 1'b1;
        end else begin
            r_bank     <= w_bank_nxt;
            r_wr_sel   <= w_wr_sel_nxt;
            r_ld_ready <= w_ld_ready_nxt;
            if (w_ld_hs) begin
                if (w_close) begin
                    r_len[r_wr_sel] <= LW'(r_wr_ptr) + LW'(1);
                    r_wr_ptr        <= '0;
                end else begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
            end
        end
    end

    // Output register: the next item is loaded on the same edge as the handshake
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rd_sel     <= 1'b0;
            r_rd_ptr     <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_batch_done <= 1'b0;
            r_batch_cnt  <= '0;
        end else begin
            r_batch_done <= w_fin;
            if (w_fin) begin
                r_batch_cnt <= r_batch_cnt + BCNT_W'(1);
                r_rd_sel    <= ~r_rd_sel;
            end
            if (w_start) begin
                r_rd_ptr    <= '0;
                r_out_data  <= r_mem[w_start_sel][PW'(0)];
                r_out_last  <= (r_len[w_start_sel] == LW'(1));
                r_out_valid <= 1'b1;
            end else if (w_adv) begin
                r_rd_ptr    <= w_rd_nxt;
                r_out_data  <= r_mem[r_rd_sel][w_rd_nxt];
                r_out_last  <= ((LW'(w_rd_nxt) + LW'(1)) == r_len[r_rd_sel]);
`ifdef TLM_GAP_EN
                r_out_valid <= 1'b0;
`endif
            end else if (w_show) begin
                r_out_valid <= 1'b1;
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

`ifdef TLM_GAP_EN
    // Idle-gap down-counter, armed by every output handshake
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_gap_cnt <= '0;
        end else if (w_hs) begin
            r_gap_cnt <= GW'(GAP_CYCLES);
        end else if (r_state == R_GAP) begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
        end
    end
`endif

    assign ld_ready_o   = r_ld_ready;
    assign out_valid_o  = r_out_valid;
    assign out_data_o   = r_out_data;
    assign out_last_o   = r_out_last;
    assign batch_done_o = r_batch_done;
    assign batch_cnt_o  = r_batch_cnt;

endmodule

// File: tb/tb_tlm_batch_pingpong_driver.sv
// Scoreboard bench for tlm_batch_pingpong_driver (DEPTH=8); define TLM_GAP_EN to exercise the gap build.
module tb_tlm_batch_pingpong_driver;

    localparam int unsigned DEPTH = 8;
`ifdef TLM_GAP_EN
    localparam int unsigned GAPC = 2;
`else
    localparam int unsigned GAPC = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        ld_valid_i = 1'b0;
    logic        ld_ready_o;
    logic [15:0] ld_data_i = '0;
    logic        ld_last_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [15:0] out_data_o;
    logic        out_last_o;
    logic        batch_done_o;
    logic [15:0] batch_cnt_o;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_hs = 0;
    int          n_done = 0;
    int          ldr_rise_cyc = -1;
    bit          ldr_armed = 1'b0;
    int          hs_cyc[$];
    logic [16:0] sb[$];
    int          bench_beat = 0;
    bit          rnd = 1'b0;
    logic        rdy_const = 1'b0;
    logic [15:0] t2 [4] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};

    tlm_batch_pingpong_driver #(
        .NUM_CH(2), .ITEM_WIDTH(8), .DEPTH(DEPTH), .GAP_CYCLES(GAPC), .BCNT_W(16)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_data_i(ld_data_i), .ld_last_i(ld_last_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .batch_done_o(batch_done_o), .batch_cnt_o(batch_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mk(input int b, input int i);
        return {8'(b * 16 + 2 * i + 2), 8'(b * 16 + 2 * i + 1)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Pops the scoreboard on every output handshake and checks stalled outputs stay put
    task automatic monitor();
        logic        p_stall;
        logic [15:0] p_data;
        logic        p_last;
        logic        p_ldr;
        logic [16:0] e;
        p_stall = 1'b0; p_data = '0; p_last = 1'b0; p_ldr = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                p_stall = 1'b0;
            end else begin
                if (p_stall)
                    chk("stall_hold", {14'b0, out_valid_o, out_last_o, out_data_o}, {14'b0, 1'b1, p_last, p_data});
                if (out_valid_o && out_ready_i) begin
                    n_hs++;
                    hs_cyc.push_back(cyc);
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_item: got %0h last %0b expected no item", out_data_o, out_last_o);
                    end else begin
                        e = sb.pop_front();
                        chk("item", {15'b0, out_last_o, out_data_o}, {15'b0, e});
                    end
                end
                p_stall = out_valid_o && !out_ready_i;
                p_data  = out_data_o;
                p_last  = out_last_o;
                if (batch_done_o) n_done++;
                if (ldr_armed && ld_ready_o && !p_ldr) begin
                    ldr_rise_cyc = cyc;
                    ldr_armed = 1'b0;
                end
            end
            p_ldr = ld_ready_o;
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #1;
            out_ready_i = rnd ? 1'($urandom_range(0, 1)) : rdy_const;
        end
    endtask

    task automatic do_reset(input int n);
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
        reset_i    = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset_i    = 1'b0;
        sb.delete();
        bench_beat = 0;
    endtask

    task automatic check_reset(input string nm);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(out_valid_o), 32'd0);
        chk({nm, "_last"}, 32'(out_last_o), 32'd0);
        chk({nm, "_data"}, 32'(out_data_o), 32'd0);
        chk({nm, "_done"}, 32'(batch_done_o), 32'd0);
        chk({nm, "_cnt"}, 32'(batch_cnt_o), 32'd0);
        chk({nm, "_ld_ready"}, 32'(ld_ready_o), 32'd1);
    endtask

    // One load beat; the expected item (with auto-close last) is queued once it is accepted
    task automatic load(input logic [15:0] d, input logic last, input bit push);
        bit   ok;
        logic eff;
        ok = 1'b0;
        ld_valid_i = 1'b1;
        ld_data_i  = d;
        ld_last_i  = last;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = ld_ready_o;
            @(posedge clk);
            #1;
        end
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL ld_timeout: got ld_ready low expected ld_ready within 300 cycles");
        end else begin
            eff = last || (bench_beat == int'(DEPTH) - 1);
            if (push) sb.push_back({eff, d});
            bench_beat = eff ? 0 : bench_beat + 1;
        end
    endtask

    task automatic wait_hs(input int target, input string nm);
        int t;
        t = 0;
        while (n_hs < target && t < 1000) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (n_hs < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got %0d handshakes expected %0d", nm, n_hs, target);
        end
    endtask

    initial begin
        int base;
        int dbase;
`ifdef TLM_GAP_EN
        logic [9:0] got_pat;
`endif
        fork
            monitor();
            ready_drv();
        join_none

        do_reset(3);
        check_reset("init");

        // Reset mid-stream and mid-batch: nothing loaded before it may ever appear
        rdy_const = 1'b0;
        for (int i = 0; i < 4; i++) load(t2[i], i == 3, 1'b0);
        load(16'hAAAA, 1'b0, 1'b0);
        load(16'hBBBB, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_valid_before_rst", 32'(out_valid_o), 32'd1);
        base = n_hs;
        do_reset(3);
        check_reset("t1");
        rdy_const = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("t1_no_stale", 32'(n_hs), 32'(base));

        // Single 4-item batch, ready held high
        base = n_hs; dbase = n_done;
        for (int i = 0; i < 4; i++) load(t2[i], i == 3, 1'b1);
        wait_hs(base + 4, "t2_drain");
`ifndef TLM_GAP_EN
        for (int i = 1; i < 4; i++) chk("t2_back_to_back", 32'(hs_cyc[base + i] - hs_cyc[base + i - 1]), 32'd1);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("t2_done_pulses", 32'(n_done - dbase), 32'd1);
        chk("t2_batch_cnt", 32'(batch_cnt_o), 32'd1);

        // Same batch under random backpressure
        base = n_hs; dbase = n_done;
        rnd = 1'b1;
        for (int i = 0; i < 4; i++) load(t2[i], i == 3, 1'b1);
        wait_hs(base + 4, "t3_drain");
        rnd = 1'b0;
        rdy_const = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_done_pulses", 32'(n_done - dbase), 32'd1);
        chk("t3_batch_cnt", 32'(batch_cnt_o), 32'd2);

        // Ping-pong: two banks filled while stalled, third batch waits for a drain
        rdy_const = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        base = n_hs; dbase = n_done;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 8; i++) load(mk(b, i), i == 7, 1'b1);
        @(negedge clk);
        chk("t4_ld_ready_low", 32'(ld_ready_o), 32'd0);
        ldr_armed = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) load(mk(2, i), i == 7, 1'b1);
            end
            begin
                @(posedge clk);
                #1;
                rdy_const = 1'b1;
                wait_hs(base + 24, "t4_drain");
            end
        join
`ifndef TLM_GAP_EN
        for (int i = 1; i < 16; i++) chk("t4_no_bubble", 32'(hs_cyc[base + i] - hs_cyc[base + i - 1]), 32'd1);
        chk("t4_ld_ready_rise", 32'(ldr_rise_cyc), 32'(hs_cyc[base + 7] + 1));
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("t4_done_pulses", 32'(n_done - dbase), 32'd3);
        chk("t4_batch_cnt", 32'(batch_cnt_o), 32'd5);

        // Auto-close at DEPTH beats; the ninth beat opens a fresh one-item batch
        base = n_hs; dbase = n_done;
        for (int i = 0; i < 8; i++) load(mk(5, i), 1'b0, 1'b1);
        load(16'h5A5A, 1'b1, 1'b1);
        wait_hs(base + 9, "t5_drain");
        repeat (3) @(posedge clk);
        #1;
        chk("t5_done_pulses", 32'(n_done - dbase), 32'd2);
        chk("t5_batch_cnt", 32'(batch_cnt_o), 32'd7);

`ifdef TLM_GAP_EN
        // Two idle cycles after every beat with ready held high
        base = n_hs;
        for (int i = 0; i < 4; i++) load(t2[i], i == 3, 1'b1);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid_o) break;
        end
        got_pat[9] = out_valid_o;
        for (int k = 8; k >= 0; k--) begin
            @(negedge clk);
            got_pat[k] = out_valid_o;
        end
        chk("t6_gap_pattern", 32'(got_pat), 32'(10'b1001001001));
        wait_hs(base + 4, "t6_drain");
        repeat (3) @(posedge clk);
        #1;
        chk("t6_batch_cnt", 32'(batch_cnt_o), 32'd8);
`endif

        repeat (4) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
